// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a single-cycle write strobe / busy handshake.
// Optional build macro UART_TX_CRLF_EN inserts a CR (0x0D) ahead of every LF (0x0A).
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_dat_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    input  logic                  clr_ovf_i,
    input  logic                  uart_busy_i,
    output logic                  uart_wr_o,
    output logic [7:0]            uart_dat_o
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  uart_wr;
    logic [7:0]            uart_dat;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  issue;
    logic [7:0]            head;
    logic [7:0]            issue_dat;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push    = wr_en_i & ~full;
    assign drop    = wr_en_i & full;
    assign head    = mem[rd_ptr];

    assign full_o     = full;
    assign empty_o    = empty;
    assign level_o    = count;
    assign overflow_o = overflow;
    assign uart_wr_o  = uart_wr;
    assign uart_dat_o = uart_dat;

`ifdef UART_TX_CRLF_EN
    logic cr_sent;
`endif

    // WAIT_ACK covers the cycle between strobe and the transmitter raising busy,
    // so the same byte is never issued twice.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        pop        = 1'b0;
        issue_dat  = head;
        case (state)
            IDLE: begin
                if (!empty && !uart_busy_i) begin
                    issue      = 1'b1;
                    state_next = WAIT_ACK;
`ifdef UART_TX_CRLF_EN
                    if (head == 8'h0A && !cr_sent) begin
                        issue_dat = 8'h0D;
                    end else begin
                        pop = 1'b1;
                    end
`else
                    pop = 1'b1;
`endif
                end
            end
            WAIT_ACK: begin
                if (uart_busy_i) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat_i;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
        end else begin
            uart_wr <= issue;
            if (issue) begin
                uart_dat <= issue_dat;
            end
        end
    end

`ifdef UART_TX_CRLF_EN
    // Set when a CR has gone out for the LF at the head; cleared once that LF pops.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            cr_sent <= 1'b0;
        end else if (issue) begin
            cr_sent <= ~pop;
        end
    end
`endif

endmodule
